// File: rtl/tdm_pkg.sv
// tdm_pkg: shared states, frame geometry and slot-index width for the TDM demux
package tdm_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_e;
  localparam int NUM_SLOTS = 4;
  localparam int PARITY_SLOT = 4;
  localparam int SLOT_W = 3;
endpackage

// File: rtl/tdm_demux_slot_ctr.sv
// tdm_demux_slot_ctr: slot index counter with load-to-1, increment and clear
module tdm_demux_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              inc,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot
);
  logic [SLOT_W-1:0] slot_q, slot_d;
  // clear wins, then load (sof restarts at slot 1), then increment
  always_comb slot_d = clr ? '0 : ld ? SLOT_W'(1) : inc ? slot_q + SLOT_W'(1) : slot_q;
  // slot register
  always_ff @(posedge clk or posedge rst)
    if (rst) slot_q <= '0;
    else slot_q <= slot_d;
  assign slot = slot_q;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 1-to-4 TDM demux with sof alignment; TDM_DEMUX_PARITY_EN adds a trailing even-parity beat
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              valid_in,
  input  logic              sof,
  output logic [WIDTH-1:0]  y0,
  output logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  y2,
  output logic [WIDTH-1:0]  y3,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              sync_err,
  output logic              parity_err
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] shadow_q [NUM_SLOTS];
  logic [WIDTH-1:0] shadow_d [NUM_SLOTS];
  logic [WIDTH-1:0] y_q [NUM_SLOTS];
  logic [WIDTH-1:0] y_d [NUM_SLOTS];
  logic frame_valid_q, frame_valid_d, sync_err_q, sync_err_d, parity_err_q, parity_err_d;
  logic ld, inc, clr;
  tdm_demux_slot_ctr u_ctr (.clk(clk), .rst(rst), .ld(ld), .inc(inc), .clr(clr), .slot(slot));
  // frame FSM: sof always (re)starts at slot 0; outputs move only on a completed frame
  always_comb begin
    state_d = state_q;
    shadow_d = shadow_q;
    y_d = y_q;
    frame_valid_d = 1'b0;
    sync_err_d = 1'b0;
    parity_err_d = 1'b0;
    ld = 1'b0;
    inc = 1'b0;
    clr = 1'b0;
    if (valid_in) begin
      if (sof) begin
        shadow_d[0] = din;
        ld = 1'b1;
        sync_err_d = state_q != IDLE;
        state_d = COLLECT;
      end else if (state_q == COLLECT) begin
        shadow_d[slot[1:0]] = din;
        if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
`ifdef TDM_DEMUX_PARITY_EN
          inc = 1'b1;
          state_d = PARITY;
`else
          y_d = shadow_d;
          frame_valid_d = 1'b1;
          clr = 1'b1;
          state_d = IDLE;
`endif
        end else inc = 1'b1;
      end
`ifdef TDM_DEMUX_PARITY_EN
      else if (state_q == PARITY) begin
        if (din == (shadow_q[0] ^ shadow_q[1] ^ shadow_q[2] ^ shadow_q[3])) begin
          y_d = shadow_q;
          frame_valid_d = 1'b1;
        end else parity_err_d = 1'b1;
        clr = 1'b1;
        state_d = IDLE;
      end
`endif
    end
  end
  // state, shadow, output and pulse registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      shadow_q <= '{default: '0};
      y_q <= '{default: '0};
      frame_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      y_q <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q <= sync_err_d;
      parity_err_q <= parity_err_d;
    end
  assign {y0, y1, y2, y3} = {y_q[0], y_q[1], y_q[2], y_q[3]};
  assign frame_valid = frame_valid_q;
  assign sync_err = sync_err_q;
  assign parity_err = parity_err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scoreboard bench for tdm_demux4 (WIDTH=1), frame length follows TDM_DEMUX_PARITY_EN
module tb_tdm_demux4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, sof = 1'b0;
  logic [0:0] din = '0, y0, y1, y2, y3;
  logic frame_valid, sync_err, parity_err;
  logic [2:0] slot;
  int tests = 0, fails = 0, cyc = 0, fv_cnt = 0, sync_cnt = 0, perr_cnt = 0, last_fv = 0, prev_fv = 0;
  logic [3:0] sb [$];
  logic [3:0] exp_y;

  tdm_demux4 #(.WIDTH(1)) dut (.clk(clk), .rst(rst), .din(din), .valid_in(valid_in), .sof(sof),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .frame_valid(frame_valid), .slot(slot),
    .sync_err(sync_err), .parity_err(parity_err));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (sync_err) sync_cnt++;
    if (parity_err) perr_cnt++;
    if (frame_valid) begin
      fv_cnt++;
      prev_fv = last_fv;
      last_fv = cyc;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_frame: got y=%b, required no frame_valid", {y0, y1, y2, y3});
      end else begin
        exp_y = sb.pop_front();
        if ({y0, y1, y2, y3} !== exp_y) begin
          fails++;
          $display("FAIL sb_frame: got y=%b, required %b", {y0, y1, y2, y3}, exp_y);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic d);
    @(negedge clk);
    valid_in = v;
    sof = s;
    din = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] d, input int gap);
    drive(1'b1, 1'b1, d[3]);
    for (int i = 2; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0);
`ifndef TDM_DEMUX_PARITY_EN
      if (i == 0) sb.push_back(d);
`endif
      drive(1'b1, 1'b0, d[i]);
    end
`ifdef TDM_DEMUX_PARITY_EN
    for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0);
    sb.push_back(d);
    drive(1'b1, 1'b0, ^d);
`endif
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if ({y0, y1, y2, y3, frame_valid, sync_err, parity_err, slot} !== 10'b0) begin
      fails++;
      $display("FAIL reset_state: got y=%b fv=%b se=%b pe=%b slot=%0d, required all 0",
        {y0, y1, y2, y3}, frame_valid, sync_err, parity_err, slot);
    end
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_ignore_and_slot;
    int f0 = fv_cnt;
    drive(1'b1, 1'b0, 1'b1);
    idle(1);
    tests++;
    if (slot !== 3'd0) begin fails++; $display("FAIL idle_ignore_slot: got %0d, required 0", slot); end
    drive(1'b1, 1'b1, 1'b1);
    idle(1);
    tests++;
    if (slot !== 3'd1) begin fails++; $display("FAIL slot_after_sof: got %0d, required 1", slot); end
    drive(1'b1, 1'b0, 1'b0);
    idle(1);
    tests++;
    if (slot !== 3'd2) begin fails++; $display("FAIL slot_after_beat2: got %0d, required 2", slot); end
    drive(1'b1, 1'b0, 1'b1);
    idle(1);
    tests++;
    if (slot !== 3'd3 || fv_cnt != f0) begin
      fails++;
      $display("FAIL slot_after_beat3: got slot=%0d frames=%0d, required 3 and %0d", slot, fv_cnt, f0);
    end
    sb.push_back(4'b1011);
`ifdef TDM_DEMUX_PARITY_EN
    drive(1'b1, 1'b0, 1'b1);
    idle(1);
    tests++;
    if (slot !== 3'd4) begin fails++; $display("FAIL slot_parity: got %0d, required 4", slot); end
    drive(1'b1, 1'b0, 1'b1);
`else
    drive(1'b1, 1'b0, 1'b1);
`endif
    idle(2);
    tests++;
    if (slot !== 3'd0 || fv_cnt != f0 + 1) begin
      fails++;
      $display("FAIL slot_frame_end: got slot=%0d frames=%0d, required 0 and %0d", slot, fv_cnt, f0 + 1);
    end
  endtask

  task automatic test_basic;
    int f0 = fv_cnt;
    send_frame(4'b1011, 0);
    idle(3);
    tests++;
    if ({y0, y1, y2, y3} !== 4'b1011 || fv_cnt != f0 + 1 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic: got y=%b frames=%0d fv=%b, required 1011, %0d, 0",
        {y0, y1, y2, y3}, fv_cnt - f0, frame_valid, 1);
    end
  endtask

  task automatic test_gapped;
    int f0 = fv_cnt;
    send_frame(4'b0110, 0);
    idle(2);
    send_frame(4'b1011, 2);
    idle(3);
    tests++;
    if ({y0, y1, y2, y3} !== 4'b1011 || fv_cnt != f0 + 2) begin
      fails++;
      $display("FAIL gapped: got y=%b frames=%0d, required 1011 and 2", {y0, y1, y2, y3}, fv_cnt - f0);
    end
  endtask

  task automatic test_resync;
    int s0 = sync_cnt, f0 = fv_cnt;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    send_frame(4'b0110, 0);
    idle(3);
    tests++;
    if (sync_cnt != s0 + 1 || fv_cnt != f0 + 1 || {y0, y1, y2, y3} !== 4'b0110) begin
      fails++;
      $display("FAIL resync: got sync_err=%0d frames=%0d y=%b, required 1, 1, 0110",
        sync_cnt - s0, fv_cnt - f0, {y0, y1, y2, y3});
    end
    s0 = sync_cnt;
    f0 = fv_cnt;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    idle(1);
    tests++;
    if (sync_err !== 1'b1 || fv_cnt != f0 || slot !== 3'd1) begin
      fails++;
      $display("FAIL resync_last_slot: got se=%b frames=%0d slot=%0d, required 1, 0, 1",
        sync_err, fv_cnt - f0, slot);
    end
    idle(1);
    tests++;
    if (sync_err !== 1'b0) begin fails++; $display("FAIL sync_err_width: got %b, required 0", sync_err); end
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
`ifndef TDM_DEMUX_PARITY_EN
    sb.push_back(4'b1001);
`endif
    drive(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    sb.push_back(4'b1001);
    drive(1'b1, 1'b0, 1'b0);
`endif
    idle(3);
    tests++;
    if ({y0, y1, y2, y3} !== 4'b1001) begin
      fails++;
      $display("FAIL resync_recover: got y=%b, required 1001", {y0, y1, y2, y3});
    end
  endtask

  task automatic test_back_to_back;
    int f0 = fv_cnt;
    send_frame(4'b1100, 0);
    send_frame(4'b0101, 0);
    idle(3);
    tests++;
    if (fv_cnt != f0 + 2 || last_fv - prev_fv != FL || {y0, y1, y2, y3} !== 4'b0101) begin
      fails++;
      $display("FAIL back_to_back: got frames=%0d spacing=%0d y=%b, required 2, %0d, 0101",
        fv_cnt - f0, last_fv - prev_fv, {y0, y1, y2, y3}, FL);
    end
  endtask

  task automatic test_parity;
`ifdef TDM_DEMUX_PARITY_EN
    int p0 = perr_cnt, f0 = fv_cnt;
    send_frame(4'b0000, 0);
    idle(2);
    send_frame(4'b1011, 0);
    idle(2);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    idle(1);
    tests++;
    if (parity_err !== 1'b1 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL parity_bad: got pe=%b fv=%b, required 1 and 0", parity_err, frame_valid);
    end
    idle(2);
    tests++;
    if (perr_cnt != p0 + 1 || fv_cnt != f0 + 2 || {y0, y1, y2, y3} !== 4'b1011 || slot !== 3'd0) begin
      fails++;
      $display("FAIL parity_hold: got perr=%0d frames=%0d y=%b slot=%0d, required 1, 2, 1011, 0",
        perr_cnt - p0, fv_cnt - f0, {y0, y1, y2, y3}, slot);
    end
`else
    send_frame(4'b1011, 0);
    drive(1'b1, 1'b0, 1'b0);
    idle(2);
    tests++;
    if (perr_cnt != 0 || {y0, y1, y2, y3} !== 4'b1011 || slot !== 3'd0) begin
      fails++;
      $display("FAIL parity_off: got perr=%0d y=%b slot=%0d, required 0, 1011, 0",
        perr_cnt, {y0, y1, y2, y3}, slot);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int f0 = fv_cnt;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    idle(1);
    rst = 1'b1;
    #1;
    tests++;
    if ({y0, y1, y2, y3} !== 4'b0 || slot !== 3'd0) begin
      fails++;
      $display("FAIL reset_mid_async: got y=%b slot=%0d, required 0000 and 0", {y0, y1, y2, y3}, slot);
    end
    idle(1);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    idle(3);
    tests++;
    if (fv_cnt != f0 || slot !== 3'd0 || {y0, y1, y2, y3} !== 4'b0) begin
      fails++;
      $display("FAIL reset_mid_discard: got frames=%0d slot=%0d y=%b, required 0, 0, 0000",
        fv_cnt - f0, slot, {y0, y1, y2, y3});
    end
  endtask

  initial begin
    test_reset;
    test_ignore_and_slot;
    test_basic;
    test_gapped;
    test_resync;
    test_back_to_back;
    test_parity;
    test_reset_mid;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending frames, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
